// File: rtl/demultiplexor_pkg.sv
// Shared constants for the stream demultiplexor: default geometry and the
// saturating error-counter definition.
package demultiplexor_pkg;

  localparam int ANCHO_DEF     = 4;
  localparam int CANALES_DEF   = 4;
  localparam int ANCHO_SEL_DEF = 3;

  localparam int                   CNT_ERR_W   = 8;
  localparam logic [CNT_ERR_W-1:0] CNT_ERR_MAX = 8'd255;

  // Increment that sticks at the ceiling instead of wrapping to zero.
  function automatic logic [CNT_ERR_W-1:0] sat_inc(input logic [CNT_ERR_W-1:0] v);
    return (v == CNT_ERR_MAX) ? CNT_ERR_MAX : v + 8'd1;
  endfunction

endpackage

// File: rtl/canal_registro.sv
// One output channel: a single-entry holding register with valid bit that
// supports load, drain and same-cycle load+drain, and reads zero when empty.
module canal_registro
  import demultiplexor_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [ANCHO-1:0] data_i,
  input  logic             y_ready_i,
  output logic             ready_o,
  output logic             y_valid_o,
  output logic [ANCHO-1:0] y_data_o
);

  logic             valid_q, valid_d;
  logic [ANCHO-1:0] data_q,  data_d;
  logic             drain;

  assign drain   = valid_q & y_ready_i;
  // Space is available if empty, or if the current word leaves this same edge.
  assign ready_o = ~valid_q | y_ready_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  // NOTE: the data register is reset too, because an empty channel must present zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign y_valid_o = valid_q;
  assign y_data_o  = data_q;

endmodule

// File: rtl/demultiplexor_stream.sv
// Routes a valid/ready input stream to one of CANALES output channels chosen by
// a 1-based selector; words with an illegal selector are dropped and counted.
module demultiplexor_stream
  import demultiplexor_pkg::*;
#(
  parameter int ANCHO     = ANCHO_DEF,
  parameter int CANALES   = CANALES_DEF,
  parameter int ANCHO_SEL = ANCHO_SEL_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic [ANCHO-1:0]         x_data,
  input  logic [ANCHO_SEL-1:0]     x_sel,
  output logic [CANALES-1:0]       y_valid,
  input  logic [CANALES-1:0]       y_ready,
  output logic [CANALES*ANCHO-1:0] y_data,
  output logic                     err_sel,
  output logic [CNT_ERR_W-1:0]     cnt_err
);

  logic [CANALES-1:0]   sel_oh;
  logic [CANALES-1:0]   ch_ready;
  logic [CANALES-1:0]   ch_load;
  logic                 sel_legal;
  logic                 drop;

  logic                 err_sel_q, err_sel_d;
  logic [CNT_ERR_W-1:0] cnt_err_q, cnt_err_d;

  // Selector value k maps to channel k-1; 0 and anything above CANALES decode to no channel.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < CANALES; i++) begin
      if (x_sel == ANCHO_SEL'(i + 1)) sel_oh[i] = 1'b1;
    end
  end

  assign sel_legal = |sel_oh;
  assign x_ready   = sel_legal ? |(sel_oh & ch_ready) : 1'b1;
  assign ch_load   = {CANALES{x_valid}} & sel_oh & ch_ready;
  assign drop      = x_valid & ~sel_legal;

  for (genvar g = 0; g < CANALES; g++) begin : g_canal
    canal_registro #(
      .ANCHO (ANCHO)
    ) u_canal (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (ch_load[g]),
      .data_i    (x_data),
      .y_ready_i (y_ready[g]),
      .ready_o   (ch_ready[g]),
      .y_valid_o (y_valid[g]),
      .y_data_o  (y_data[g*ANCHO +: ANCHO])
    );
  end

  always_comb begin
    err_sel_d = drop;
    cnt_err_d = drop ? sat_inc(cnt_err_q) : cnt_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel_q <= 1'b0;
      cnt_err_q <= '0;
    end else begin
      err_sel_q <= err_sel_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign err_sel = err_sel_q;
  assign cnt_err = cnt_err_q;

endmodule

// File: tb/tb_demultiplexor_stream.sv
// Self-checking bench for demultiplexor_stream: a per-channel behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_demultiplexor_stream;

  localparam int W  = 4;
  localparam int CH = 4;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            x_valid;
  logic            x_ready;
  logic [W-1:0]    x_data;
  logic [SW-1:0]   x_sel;
  logic [CH-1:0]   y_valid;
  logic [CH-1:0]   y_ready;
  logic [CH*W-1:0] y_data;
  logic            err_sel;
  logic [7:0]      cnt_err;

  int n_checks = 0;
  int n_fail   = 0;

  demultiplexor_stream #(.ANCHO(W), .CANALES(CH), .ANCHO_SEL(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x_data  (x_data),
    .x_sel   (x_sel),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_data  (y_data),
    .err_sel (err_sel),
    .cnt_err (cnt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what each channel holds, plus the error pulse and count.
  bit       m_valid [CH];
  bit [W-1:0] m_data [CH];
  bit       m_err;
  int       m_cnt;

  function automatic bit m_legal(input logic [SW-1:0] s);
    return (int'(s) >= 1) && (int'(s) <= CH);
  endfunction

  function automatic bit m_x_ready();
    int tgt;
    if (!m_legal(x_sel)) return 1'b1;
    tgt = int'(x_sel) - 1;
    return !m_valid[tgt] || y_ready[tgt];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_valid[c] = 1'b0;
      m_data[c]  = '0;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (rst_n) begin
      bit acc;
      acc = x_valid && m_x_ready();
      for (int c = 0; c < CH; c++) begin
        if (acc && m_legal(x_sel) && (int'(x_sel) - 1 == c)) begin
          m_valid[c] = 1'b1;
          m_data[c]  = x_data;
        end else if (m_valid[c] && y_ready[c]) begin
          m_valid[c] = 1'b0;
          m_data[c]  = '0;
        end
      end
      m_err = x_valid && !m_legal(x_sel);
      if (m_err && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  end

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      check($sformatf("model y_valid[%0d]", c), 32'(y_valid[c]), 32'(m_valid[c]));
      check($sformatf("model y_data[%0d]", c), 32'(y_data[c*W +: W]), 32'(m_data[c]));
    end
    check("model x_ready", 32'(x_ready), 32'(m_x_ready()));
    check("model err_sel", 32'(err_sel), 32'(m_err));
    check("model cnt_err", 32'(cnt_err), 32'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] s, input logic [W-1:0] d);
    x_valid = v;
    x_sel   = s;
    x_data  = d;
  endtask

  initial begin
    rst_n   = 1'b0;
    y_ready = '0;
    drive(1'b1, 3'd3, 4'hA);

    // Reset held with a valid word presented: nothing may appear.
    repeat (3) begin
      step();
      check("rst y_valid", 32'(y_valid), 32'h0);
      check("rst y_data", 32'(y_data), 32'h0);
      check("rst err_sel", 32'(err_sel), 32'h0);
      check("rst cnt_err", 32'(cnt_err), 32'h0);
    end
    rst_n = 1'b1;
    step();
    check("first xfer y_valid", 32'(y_valid), 32'h4);
    check("first xfer ch2 data", 32'(y_data[11:8]), 32'hA);

    // Drain, then stall channel 0.
    drive(1'b0, 3'd0, 4'h0);
    y_ready = 4'b1111;
    step();
    y_ready = 4'b0000;
    drive(1'b1, 3'd1, 4'h3);
    step();
    check("stall ch0 loaded", 32'(y_data[3:0]), 32'h3);
    drive(1'b1, 3'd1, 4'h7);
    #1;
    check("stall x_ready sel1", 32'(x_ready), 32'h0);
    drive(1'b1, 3'd2, 4'h5);
    #1;
    check("stall x_ready sel2", 32'(x_ready), 32'h1);
    step();
    check("stall y_valid", 32'(y_valid), 32'h3);
    check("stall ch1 data", 32'(y_data[7:4]), 32'h5);
    check("stall ch0 held", 32'(y_data[3:0]), 32'h3);
    drive(1'b0, 3'd0, 4'h0);
    y_ready = 4'b1111;
    step();
    check("drain all", 32'(y_valid), 32'h0);

    // Streaming into channel 3 with the sink always ready.
    for (int d = 1; d <= 8; d++) begin
      drive(1'b1, 3'd4, W'(d));
      #1;
      check("stream x_ready", 32'(x_ready), 32'h1);
      step();
      check("stream y_valid", 32'(y_valid), 32'h8);
      check("stream ch3 data", 32'(y_data[15:12]), 32'(d));
    end
    drive(1'b0, 3'd0, 4'h0);
    step();

    // Illegal selectors 0 and 5.
    drive(1'b1, 3'd0, 4'h7);
    #1;
    check("illegal x_ready sel0", 32'(x_ready), 32'h1);
    step();
    check("illegal0 err_sel", 32'(err_sel), 32'h1);
    check("illegal0 cnt", 32'(cnt_err), 32'h1);
    drive(1'b1, 3'd5, 4'h6);
    step();
    check("illegal5 err_sel", 32'(err_sel), 32'h1);
    check("illegal5 cnt", 32'(cnt_err), 32'h2);
    check("illegal y_valid", 32'(y_valid), 32'h0);
    drive(1'b0, 3'd5, 4'h6);
    step();
    check("illegal err drop", 32'(err_sel), 32'h0);
    check("illegal cnt hold", 32'(cnt_err), 32'h2);

    // Saturation of the error counter.
    drive(1'b1, 3'd7, 4'h1);
    repeat (300) step();
    check("sat cnt", 32'(cnt_err), 32'd255);
    drive(1'b1, 3'd6, 4'h2);
    step();
    check("sat cnt hold", 32'(cnt_err), 32'd255);
    drive(1'b1, 3'd1, 4'h9);
    step();
    check("post-sat y_valid", 32'(y_valid), 32'h1);
    check("post-sat ch0 data", 32'(y_data[3:0]), 32'h9);
    check("post-sat err_sel", 32'(err_sel), 32'h0);
    check("post-sat cnt", 32'(cnt_err), 32'd255);

    // Asynchronous reset with channels 0 and 2 full.
    drive(1'b0, 3'd0, 4'h0);
    step();
    y_ready = 4'b0000;
    drive(1'b1, 3'd1, 4'h2);
    step();
    drive(1'b1, 3'd3, 4'hC);
    step();
    drive(1'b0, 3'd0, 4'h0);
    check("pre-rst y_valid", 32'(y_valid), 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst y_valid", 32'(y_valid), 32'h0);
    check("async rst y_data", 32'(y_data), 32'h0);
    check("async rst cnt", 32'(cnt_err), 32'h0);
    step();
    rst_n   = 1'b1;
    y_ready = 4'b1111;
    repeat (3) begin
      step();
      check("post-rst y_valid", 32'(y_valid), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demultiplexor_stream.md
DEMULTIPLEXOR_STREAM -- requirements
Module: demultiplexor_stream

Interface
REQ-001 Parameter ANCHO, default 4, data width in bits per channel (>=1).
REQ-002 Parameter CANALES, default 4, number of output channels (2..8).
REQ-003 Parameter ANCHO_SEL, default 3, selector width; SHALL satisfy 2**ANCHO_SEL > CANALES.
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 x_valid  input  1  input word present.
REQ-008 x_ready  output  1  block accepts the input word this cycle.
REQ-009 x_data  input  ANCHO  input word.
REQ-010 x_sel  input  ANCHO_SEL  1-based destination; value k routes to channel k-1.
REQ-011 y_valid  output  CANALES  per-channel word present.
REQ-012 y_ready  input  CANALES  per-channel sink accepts.
REQ-013 y_data  output  CANALES*ANCHO  channel i occupies bits [i*ANCHO +: ANCHO].
REQ-014 err_sel  output  1  one-cycle pulse: a word with an illegal selector was dropped.
REQ-015 cnt_err  output  8  count of dropped words, saturating.

Function
REQ-016 Legal selector: 1 <= x_sel <= CANALES. Any other value (including 0) is illegal.
REQ-017 Each channel SHALL own one holding register (valid bit plus ANCHO data).
REQ-018 Legal selector: x_ready SHALL be high when the target register is empty, or full with its y_ready high in the same cycle. Combinational y_ready-to-x_ready path is permitted.
REQ-019 Illegal selector: x_ready SHALL be high unconditionally, and the word is consumed and dropped.
REQ-020 Transfer occurs when x_valid and x_ready are both high at the rising edge of clk.
REQ-021 Legal transfer: the target register loads x_data, and its y_valid asserts in the next cycle (latency 1).
REQ-022 Output drain occurs when y_valid[i] and y_ready[i] are both high at the edge. With no simultaneous load, y_valid[i] clears and y_data[i] becomes 0.
REQ-023 Simultaneous drain and load on the same channel: the register takes the new word, and y_valid[i] stays high with no bubble.
REQ-024 y_data[i] SHALL be 0 whenever y_valid[i] is 0.
REQ-025 Once y_valid[i] is high, y_data[i] SHALL be held stable until drained.
REQ-026 Channels are independent: a stalled channel SHALL NOT block words addressed to other channels.
REQ-027 x_ready SHALL be decoded from the current x_sel even when x_valid is low. It has no effect without x_valid.
REQ-028 Illegal transfer: err_sel SHALL pulse high for exactly one cycle, the cycle after the transfer.
REQ-029 Illegal transfer: cnt_err SHALL increment by 1, holding at 255 (no wrap).
REQ-030 Back-to-back illegal transfers SHALL keep err_sel high for consecutive cycles and increment cnt_err each cycle.
REQ-031 x_data and x_sel are don't-care when x_valid is low, and no state changes.

Reset
REQ-032 While rst_n is low, every y_valid SHALL be 0, every y_data SHALL be 0, err_sel SHALL be 0 and cnt_err SHALL be 0, independent of clk.
REQ-033 Reset mid-operation SHALL discard all held words without emitting them.
REQ-034 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-035 Package demultiplexor_pkg SHALL hold the default parameter values, the 8-bit error counter width and its saturation constant (255).
REQ-036 Sub-module canal_registro SHALL implement one channel holding register (load, drain, simultaneous load/drain, zero-on-empty). It is instantiated CANALES times via generate.
REQ-037 Selector decode, ready mux and error counter SHALL reside in demultiplexor_stream.

Verification
REQ-038 Reset with x_valid=1: all outputs stay 0 while rst_n=0. After release, x_sel=3, x_data=4'hA -> y_valid=4'b0100 and channel 2 data = 4'hA one cycle later.
REQ-039 Stall: channel 0 full with y_ready[0]=0.
  - x_sel=1 -> x_ready=0.
  - Same cycle, x_sel=2, x_data=4'h5 -> accepted, and channel 1 shows 4'h5 next cycle.
REQ-040 Streaming: y_ready=4'b1111, x_sel=4 every cycle, data 1,2,3,...,8.
  - Channel 3 emits 1..8 in order, one per cycle.
  - x_ready stays 1 throughout.
REQ-041 Illegal selector: x_sel=0, then x_sel=5 (CANALES=4).
  - Both words accepted, and no y_valid asserts.
  - err_sel is high 2 consecutive cycles, and cnt_err=2.
REQ-042 Saturation: 300 illegal transfers -> cnt_err=255 and stays 255. Then a legal x_sel=1 word still routes correctly.
REQ-043 Reset mid-operation: channels 0 and 2 full, assert rst_n=0 asynchronously between edges.
  - y_valid=0 and y_data=0 immediately.
  - No held word appears after release.
